// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache between the MEM
// stage and the SRAM controller; read hits complete in the request cycle.
module dcache_ctrl #(
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        flush,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        sram_r_en,
    output logic        sram_w_en,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic        sram_ready,
    input  logic [63:0] sram_rdata,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
);
    localparam int LINES  = 1 << INDEX_W;
    localparam int TAG_LO = 3 + INDEX_W;
    localparam int TAG_HI = TAG_LO + TAG_W - 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RD_MISS = 2'd1;
    localparam logic [1:0] S_WR_THRU = 2'd2;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    logic [1:0]         state;
    req_t               lat;
    logic [LINES-1:0]   valid;
    logic [TAG_W-1:0]   tags  [LINES];
    logic [63:0]        lines [LINES];

    logic [INDEX_W-1:0] idx, lat_idx;
    logic [TAG_W-1:0]   tag, lat_tag;
    logic               hit, lat_hit;
    logic [63:0]        cur_line;
    logic               fill_en, upd_en;

    assign idx     = addr[TAG_LO-1:3];
    assign tag     = addr[TAG_HI:TAG_LO];
    assign lat_idx = lat.addr[TAG_LO-1:3];
    assign lat_tag = lat.addr[TAG_HI:TAG_LO];

    assign cur_line = lines[idx];
    assign hit      = valid[idx] && (tags[idx] == tag);
    assign lat_hit  = valid[lat_idx] && (tags[lat_idx] == lat_tag);

    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[1:0], addr[31:TAG_HI+1]};

    assign sram_r_en  = rst && (state == S_RD_MISS);
    assign sram_w_en  = rst && (state == S_WR_THRU);
    assign sram_addr  = lat.addr;
    assign sram_wdata = lat.wdata;

    assign fill_en = sram_r_en && sram_ready;
    assign upd_en  = sram_w_en && sram_ready && lat_hit;

    // sram_ready is only meaningful while a transaction is outstanding.
    always_comb begin
        ready = 1'b0;
        rdata = '0;
        if (rst) begin
            case (state)
                S_IDLE: begin
                    ready = !flush && !mem_w_en && (!mem_r_en || hit);
                    if (!flush && !mem_w_en && mem_r_en && hit)
                        rdata = addr[2] ? cur_line[63:32] : cur_line[31:0];
                end
                S_RD_MISS: begin
                    ready = sram_ready;
                    if (sram_ready)
                        rdata = lat.addr[2] ? sram_rdata[63:32] : sram_rdata[31:0];
                end
                S_WR_THRU: ready = sram_ready;
                default:   ready = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            valid    <= '0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
            lat      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (flush) begin
                        valid <= '0;
                    end else if (mem_w_en) begin
                        lat   <= '{addr: addr, wdata: wdata};
                        state <= S_WR_THRU;
                    end else if (mem_r_en) begin
                        if (hit) begin
                            if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
                        end else begin
                            lat.addr <= addr;
                            state    <= S_RD_MISS;
                            if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
                        end
                    end
                end
                S_RD_MISS: begin
                    if (sram_ready) begin
                        valid[lat_idx] <= 1'b1;
                        state          <= S_IDLE;
                    end
                end
                S_WR_THRU: if (sram_ready) state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

    // Tag/data arrays carry no reset; valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tags[lat_idx]  <= lat_tag;
            lines[lat_idx] <= sram_rdata;
        end else if (upd_en) begin
            lines[lat_idx][{lat.addr[2], 5'b0} +: 32] <= lat.wdata;
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a fixed-latency SRAM controller model.
module tb_dcache_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_r_en, mem_w_en, flush;
    logic [31:0] addr, wdata;
    logic        ready;
    logic [31:0] rdata;
    logic        sram_r_en, sram_w_en;
    logic [31:0] sram_addr, sram_wdata;
    logic        sram_ready;
    logic [63:0] sram_rdata;
    logic [15:0] hit_cnt, miss_cnt;

    int errors = 0;
    int checks = 0;

    dcache_ctrl dut (
        .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .addr(addr), .wdata(wdata), .flush(flush), .ready(ready), .rdata(rdata),
        .sram_r_en(sram_r_en), .sram_w_en(sram_w_en), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_ready(sram_ready), .sram_rdata(sram_rdata),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    // Controller model: sram_ready high when idle, asserted on the 6th request cycle.
    int  lat_cnt;
    logic req;
    assign req        = sram_r_en | sram_w_en;
    assign sram_ready = !req || (lat_cnt == 5);
    always_ff @(posedge clk) begin
        if (!rst || !req || sram_ready) lat_cnt <= 0;
        else                            lat_cnt <= lat_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, output int cyc, output logic saw_r,
                        output logic saw_w, output logic [31:0] rd_o,
                        output logic [31:0] sa, output logic [31:0] sd);
        @(posedge clk); #1;
        mem_r_en = r; mem_w_en = w; addr = a; wdata = d;
        cyc = 0; saw_r = 1'b0; saw_w = 1'b0;
        @(negedge clk);
        while (!ready && cyc < 40) begin
            @(negedge clk);
            cyc++;
            saw_r |= sram_r_en;
            saw_w |= sram_w_en;
        end
        rd_o = rdata; sa = sram_addr; sd = sram_wdata;
        @(posedge clk); #1;
        mem_r_en = 1'b0; mem_w_en = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp,
                      input int exp_cyc);
        int cyc; logic sr, sw; logic [31:0] d, sa, sd;
        xfer(1'b1, 1'b0, a, 32'h0, cyc, sr, sw, d, sa, sd);
        chk({tag, "_data"}, d, exp);
        chk({tag, "_cyc"}, cyc, exp_cyc);
        chk({tag, "_sram_r"}, {31'b0, sr}, {31'b0, exp_cyc != 0});
    endtask

    task automatic wr(input string tag, input logic r, input logic [31:0] a,
                      input logic [31:0] d);
        int cyc; logic sr, sw; logic [31:0] rd_o, sa, sd;
        xfer(r, 1'b1, a, d, cyc, sr, sw, rd_o, sa, sd);
        chk({tag, "_cyc"}, cyc, 6);
        chk({tag, "_sram_w"}, {31'b0, sw}, 32'd1);
        chk({tag, "_no_sram_r"}, {31'b0, sr}, 32'd0);
        chk({tag, "_sram_addr"}, sa, a);
        chk({tag, "_sram_wdata"}, sd, d);
    endtask

    initial begin
        rst = 1'b0; mem_r_en = 1'b1; mem_w_en = 1'b0; flush = 1'b0;
        addr = 32'h400; wdata = 32'h0; sram_rdata = 64'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'b0, ready}, 32'd0);
        chk("rst_sram_r", {31'b0, sram_r_en}, 32'd0);
        chk("rst_sram_w", {31'b0, sram_w_en}, 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_hit_cnt", {16'b0, hit_cnt}, 32'd0);
        chk("rst_miss_cnt", {16'b0, miss_cnt}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1; mem_r_en = 1'b0;

        sram_rdata = 64'h2222_2222_1111_1111;
        rd("cold_400", 32'h400, 32'h1111_1111, 6);
        chk("miss_cnt_1", {16'b0, miss_cnt}, 32'd1);
        rd("hit_404", 32'h404, 32'h2222_2222, 0);
        chk("hit_cnt_1", {16'b0, hit_cnt}, 32'd1);

        wr("wr_404", 1'b0, 32'h404, 32'hDEAD_BEEF);
        rd("hit_404_upd", 32'h404, 32'hDEAD_BEEF, 0);
        rd("hit_400_keep", 32'h400, 32'h1111_1111, 0);
        chk("hit_cnt_3", {16'b0, hit_cnt}, 32'd3);

        wr("wr_800", 1'b0, 32'h800, 32'hCAFE_F00D);
        chk("wr_no_count", {hit_cnt, miss_cnt}, {16'd3, 16'd1});
        sram_rdata = 64'h4444_4444_3333_3333;
        rd("rd_800_noalloc", 32'h800, 32'h3333_3333, 6);
        chk("miss_cnt_2", {16'b0, miss_cnt}, 32'd2);

        sram_rdata = 64'h2222_2222_1111_1111;
        rd("alias_400", 32'h400, 32'h1111_1111, 6);
        sram_rdata = 64'h6666_6666_5555_5555;
        rd("alias_600", 32'h600, 32'h5555_5555, 6);
        sram_rdata = 64'h2222_2222_1111_1111;
        rd("alias_400_again", 32'h400, 32'h1111_1111, 6);
        chk("miss_cnt_5", {16'b0, miss_cnt}, 32'd5);

        @(posedge clk); #1;
        flush = 1'b1; mem_r_en = 1'b1; addr = 32'h400;
        @(negedge clk);
        chk("flush_ready", {31'b0, ready}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; mem_r_en = 1'b0;
        chk("flush_no_count", {hit_cnt, miss_cnt}, {16'd3, 16'd5});
        sram_rdata = 64'h8888_8888_7777_7777;
        rd("after_flush_400", 32'h400, 32'h7777_7777, 6);
        chk("miss_cnt_6", {16'b0, miss_cnt}, 32'd6);

        wr("both_404", 1'b1, 32'h404, 32'h1234_5678);
        chk("both_miss_cnt", {16'b0, miss_cnt}, 32'd6);
        rd("both_hit_404", 32'h404, 32'h1234_5678, 0);
        chk("hit_cnt_4", {16'b0, hit_cnt}, 32'd4);

        // reset while a refill is outstanding
        @(posedge clk); #1;
        mem_r_en = 1'b1; addr = 32'h200;
        repeat (3) @(negedge clk);
        chk("mid_sram_r", {31'b0, sram_r_en}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0; mem_r_en = 1'b0;
        @(negedge clk);
        chk("mid_rst_sram_r", {31'b0, sram_r_en}, 32'd0);
        chk("mid_rst_ready", {31'b0, ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", {31'b0, ready}, 32'd1);
        chk("post_rst_cnt", {hit_cnt, miss_cnt}, 32'd0);
        sram_rdata = 64'hAAAA_AAAA_9999_9999;
        rd("post_rst_404", 32'h404, 32'hAAAA_AAAA, 6);

        // saturate the hit counter with a held read hit
        @(posedge clk); #1;
        mem_r_en = 1'b1; addr = 32'h404;
        repeat (65540) @(posedge clk);
        #1 mem_r_en = 1'b0;
        chk("hit_cnt_sat", {16'b0, hit_cnt}, 32'h0000_FFFF);
        chk("miss_cnt_hold", {16'b0, miss_cnt}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
